// File: rtl/sd_tx_fifo_gen.sv
// Single-clock SD transmit FIFO with FWFT or registered read,
// fill/free counters, threshold flags, flush and sticky error flags.
module sd_tx_fifo_gen #(
  parameter int DATA_W    = 32,
  parameter int ADR_W     = 4,
  parameter int AFULL_TH  = 12,
  parameter int AEMPTY_TH = 2,
  parameter int FWFT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [DATA_W-1:0] d,
  input  logic              wr,
  input  logic              rd,
  output logic [DATA_W-1:0] q,
  output logic              q_valid,
  output logic              full,
  output logic              empty,
  output logic              afull,
  output logic              aempty,
  output logic [ADR_W:0]    level,
  output logic [ADR_W:0]    free,
  output logic              ovf,
  output logic              udf,
  input  logic              err_clr
);

  localparam int             DEPTH   = 1 << ADR_W;
  localparam logic [ADR_W:0] DEPTH_V = (ADR_W+1)'(DEPTH);
  localparam logic [ADR_W:0] AF_V    = (ADR_W+1)'(AFULL_TH);
  localparam logic [ADR_W:0] AE_V    = (ADR_W+1)'(AEMPTY_TH);
  localparam logic [ADR_W:0] ONE     = (ADR_W+1)'(1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADR_W:0]    wr_ptr_q, wr_ptr_d;
  logic [ADR_W:0]    rd_ptr_q, rd_ptr_d;
  logic              ovf_q, ovf_d;
  logic              udf_q, udf_d;
  logic              wr_acc, rd_acc;

  // One extra pointer bit tells full from empty.
  assign level  = wr_ptr_q - rd_ptr_q;
  assign free   = DEPTH_V - level;
  assign full   = (level == DEPTH_V);
  assign empty  = (level == '0);
  assign afull  = (level >= AF_V);
  assign aempty = (level <= AE_V);
  assign ovf    = ovf_q;
  assign udf    = udf_q;

  always_comb begin
    wr_acc   = wr & ~full & ~flush;
    rd_acc   = rd & ~empty & ~flush;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + ONE;
      if (rd_acc) rd_ptr_d = rd_ptr_q + ONE;
    end
    // A new event outranks a coincident clear.
    ovf_d = (ovf_q & ~err_clr) | (wr & full & ~flush);
    udf_d = (udf_q & ~err_clr) | (rd & empty & ~flush);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_acc) mem_q[wr_ptr_q[ADR_W-1:0]] <= d;
  end

  if (FWFT != 0) begin : g_fwft
    assign q       = mem_q[rd_ptr_q[ADR_W-1:0]];
    assign q_valid = ~empty;
  end else begin : g_reg
    logic [DATA_W-1:0] q_q, q_d;
    logic              qv_q, qv_d;

    always_comb begin
      q_d  = q_q;
      qv_d = rd_acc;
      if (rd_acc) q_d = mem_q[rd_ptr_q[ADR_W-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        q_q  <= '0;
        qv_q <= 1'b0;
      end else begin
        q_q  <= q_d;
        qv_q <= qv_d;
      end
    end

    assign q       = q_q;
    assign q_valid = qv_q;
  end

endmodule
